// File: rtl/fib_datapath.sv
`default_nettype none
// ============================================================================
// Module   : fib_datapath
// Purpose  : 3-register bank + small ALU driven by a 9-bit control word,
//            with registered compare flag, sticky carry/borrow and write count.
// Revision : 1.0 - initial release
// ============================================================================
module fib_datapath #(
  parameter int WIDTH   = 8,
  parameter int ITER_W  = 8,
  parameter int INIT_R1 = 0,
  parameter int INIT_R2 = 1,
  parameter int INIT_R3 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        i_signal,
  input  logic [WIDTH-1:0]  i_limit,
  output logic              o_mayor,
  output logic [WIDTH-1:0]  o_result,
  output logic [WIDTH-1:0]  o_r1,
  output logic [WIDTH-1:0]  o_r2,
  output logic              o_ovf,
  output logic [ITER_W-1:0] o_iter
);

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_PA  = 2'b10;
  localparam logic [1:0] c_WR_R1  = 2'b00;
  localparam logic [1:0] c_WR_R2  = 2'b01;
  localparam logic [1:0] c_WR_R3  = 2'b10;
  localparam logic [1:0] c_WR_NONE = 2'b11;

  logic [1:0]        w_op, w_sel_a, w_sel_b, w_wr_sel;
  logic              w_we;
  logic [WIDTH-1:0]  w_a, w_b, w_res;
  logic [WIDTH:0]    w_sum;
  logic              w_flag;

  logic [WIDTH-1:0]  r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic              mayor_q, mayor_d, ovf_q, ovf_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  assign w_op     = i_signal[8:7];
  assign w_sel_a  = i_signal[6:5];
  assign w_sel_b  = i_signal[4:3];
  assign w_wr_sel = i_signal[2:1];
  assign w_we     = i_signal[0];

  always_comb begin
    case (w_sel_a)
      2'b00:   w_a = r1_q;
      2'b01:   w_a = r2_q;
      2'b10:   w_a = r3_q;
      default: w_a = i_limit;
    endcase
    case (w_sel_b)
      2'b00:   w_b = r1_q;
      2'b01:   w_b = r2_q;
      2'b10:   w_b = r3_q;
      default: w_b = i_limit;
    endcase
  end

  // w_flag is carry-out for add, borrow (A<B) for sub, never for pass ops
  always_comb begin
    w_sum  = '0;
    w_flag = 1'b0;
    case (w_op)
      c_OP_ADD: begin
        w_sum  = {1'b0, w_a} + {1'b0, w_b};
        w_flag = w_sum[WIDTH];
      end
      c_OP_SUB: begin
        w_sum  = {1'b0, w_a} - {1'b0, w_b};
        w_flag = (w_a < w_b);
      end
      c_OP_PA:  w_sum = {1'b0, w_a};
      default:  w_sum = {1'b0, w_b};
    endcase
    w_res = w_sum[WIDTH-1:0];
  end

  always_comb begin
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    ovf_d   = ovf_q;
    iter_d  = iter_q;
    mayor_d = (r3_q > i_limit);
    if (w_we) begin
      case (w_wr_sel)
        c_WR_R1: r1_d = w_res;
        c_WR_R2: r2_d = w_res;
        c_WR_R3: begin
          r3_d = w_res;
          if (iter_q != {ITER_W{1'b1}}) iter_d = iter_q + 1'b1;
        end
        default: ;
      endcase
      if (w_wr_sel != c_WR_NONE && w_flag) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_q    <= WIDTH'(INIT_R1);
      r2_q    <= WIDTH'(INIT_R2);
      r3_q    <= WIDTH'(INIT_R3);
      mayor_q <= 1'b0;
      ovf_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      mayor_q <= mayor_d;
      ovf_q   <= ovf_d;
      iter_q  <= iter_d;
    end
  end

  assign o_mayor  = mayor_q;
  assign o_result = r3_q;
  assign o_r1     = r1_q;
  assign o_r2     = r2_q;
  assign o_ovf    = ovf_q;
  assign o_iter   = iter_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_datapath
// Purpose  : Directed, table-driven self-checking bench for fib_datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_datapath;

  localparam logic [8:0] c_ADD3 = 9'b000001101; // R3 <= R1 + R2
  localparam logic [8:0] c_R1R2 = 9'b100100001; // R1 <= R2
  localparam logic [8:0] c_R2R3 = 9'b101000011; // R2 <= R3
  localparam logic [8:0] c_NOP  = 9'b000001111; // we=1, wr_sel=11
  localparam logic [8:0] c_LDR1 = 9'b101100001; // R1 <= i_limit (pass A)
  localparam logic [8:0] c_LDR2 = 9'b110011011; // R2 <= i_limit (pass B)
  localparam logic [8:0] c_SUB3 = 9'b010001101; // R3 <= R1 - R2
  localparam logic [8:0] c_PB3  = 9'b110011101; // R3 <= i_limit (pass B)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] i_signal = '0;
  logic [7:0] i_limit = '0;
  logic       o_mayor, o_ovf;
  logic [7:0] o_result, o_r1, o_r2, o_iter;

  int checks = 0;
  int failures = 0;

  fib_datapath dut (
    .clk(clk), .rst(rst), .i_signal(i_signal), .i_limit(i_limit),
    .o_mayor(o_mayor), .o_result(o_result), .o_r1(o_r1), .o_r2(o_r2),
    .o_ovf(o_ovf), .o_iter(o_iter)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] sig;
    logic [7:0] lim;
    logic [7:0] r1, r2, r3;
    logic       mayor, ovf;
    logic [7:0] iter;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [8:0] sig, input logic [7:0] lim);
    i_signal = sig;
    i_limit  = lim;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] r1, input logic [7:0] r2,
                         input logic [7:0] r3, input logic m, input logic ov,
                         input logic [7:0] it);
    chk({tag, ".r1"}, 32'(o_r1), 32'(r1));
    chk({tag, ".r2"}, 32'(o_r2), 32'(r2));
    chk({tag, ".r3"}, 32'(o_result), 32'(r3));
    chk({tag, ".mayor"}, 32'(o_mayor), 32'(m));
    chk({tag, ".ovf"}, 32'(o_ovf), 32'(ov));
    chk({tag, ".iter"}, 32'(o_iter), 32'(it));
  endtask

  task automatic do_reset();
    i_signal = '0;
    #2 rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Fibonacci loop with i_limit=20: R3 = 1,2,3,5,8,13,21
    tbl[0]  = '{c_ADD3, 20, 0, 1, 1, 0, 0, 1};
    tbl[1]  = '{c_R1R2, 20, 1, 1, 1, 0, 0, 1};
    tbl[2]  = '{c_R2R3, 20, 1, 1, 1, 0, 0, 1};
    tbl[3]  = '{c_ADD3, 20, 1, 1, 2, 0, 0, 2};
    tbl[4]  = '{c_R1R2, 20, 1, 1, 2, 0, 0, 2};
    tbl[5]  = '{c_R2R3, 20, 1, 2, 2, 0, 0, 2};
    tbl[6]  = '{c_ADD3, 20, 1, 2, 3, 0, 0, 3};
    tbl[7]  = '{c_R1R2, 20, 2, 2, 3, 0, 0, 3};
    tbl[8]  = '{c_R2R3, 20, 2, 3, 3, 0, 0, 3};
    tbl[9]  = '{c_ADD3, 20, 2, 3, 5, 0, 0, 4};
    tbl[10] = '{c_R1R2, 20, 3, 3, 5, 0, 0, 4};
    tbl[11] = '{c_R2R3, 20, 3, 5, 5, 0, 0, 4};
    tbl[12] = '{c_ADD3, 20, 3, 5, 8, 0, 0, 5};
    tbl[13] = '{c_R1R2, 20, 5, 5, 8, 0, 0, 5};
    tbl[14] = '{c_R2R3, 20, 5, 8, 8, 0, 0, 5};
    tbl[15] = '{c_ADD3, 20, 5, 8, 13, 0, 0, 6};
    tbl[16] = '{c_R1R2, 20, 8, 8, 13, 0, 0, 6};
    tbl[17] = '{c_R2R3, 20, 8, 13, 13, 0, 0, 6};
    tbl[18] = '{c_ADD3, 20, 8, 13, 21, 0, 0, 7};
    tbl[19] = '{9'd0,   20, 8, 13, 21, 1, 0, 7};
    tbl[20] = '{9'd0,   21, 8, 13, 21, 0, 0, 7};  // equal -> not greater
    tbl[21] = '{c_NOP,  21, 8, 13, 21, 0, 0, 7};

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].sig, tbl[i].lim);
      chk_all($sformatf("vec%0d", i), tbl[i].r1, tbl[i].r2, tbl[i].r3,
              tbl[i].mayor, tbl[i].ovf, tbl[i].iter);
    end

    // Compare latency: i_limit=0, one R3 write, flag one edge later
    do_reset();
    step(c_ADD3, 0);
    chk("lat.r3", 32'(o_result), 1);
    chk("lat.iter", 32'(o_iter), 1);
    chk("lat.mayor0", 32'(o_mayor), 0);
    step(9'd0, 0);
    chk("lat.mayor1", 32'(o_mayor), 1);
    do_reset();
    step(c_ADD3, 1);
    step(9'd0, 1);
    step(9'd0, 1);
    chk("lat.eq_mayor", 32'(o_mayor), 0);

    // Load via pass ops (no ovf), then overflowing add
    do_reset();
    step(c_LDR1, 200);
    step(c_LDR2, 100);
    chk_all("load", 200, 100, 0, 0, 0, 0);
    step(c_ADD3, 100);
    chk("ovf.r3", 32'(o_result), 44);
    chk("ovf.set", 32'(o_ovf), 1);
    step(9'd0, 100);
    chk("ovf.sticky", 32'(o_ovf), 1);
    step(c_NOP, 100);
    chk_all("nop", 200, 100, 44, 0, 1, 1);

    // Async reset mid-cycle, no clock edge needed
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Borrow on subtract, then iteration counter saturation
    step(c_SUB3, 0);
    chk("sub.r3", 32'(o_result), 255);
    chk("sub.ovf", 32'(o_ovf), 1);
    for (int k = 1; k < 254; k++) step(c_PB3, 8'(k));
    chk("iter254", 32'(o_iter), 254);
    step(c_PB3, 7);
    chk("iter255", 32'(o_iter), 255);
    chk("pb.r3", 32'(o_result), 7);
    repeat (5) step(c_PB3, 9);
    chk("iter_sat", 32'(o_iter), 255);
    chk("sat.r3", 32'(o_result), 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
